serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built around one full-adder cell.
// Operands are captured on start, summed LSB-first, result published on DONE.
`default_nettype none

module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic           fa_s;
  logic           fa_co;
  logic           last_bit;

  // The single full-adder cell of the datapath.
  assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_co    = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign last_bit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {fa_s, res_q[N-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB, held in the carry FF.
          sum_d   = {fa_s, res_q[N-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (N=8).
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done;
  logic [7:0] sum;
  logic       c_out, overflow;

  int total = 0;
  int bad   = 0;

  serial_adder #(.N(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns 1 time unit after the accepting edge.
  task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; c_in = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance edge by edge until done is seen (bounded); n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, sum, c_out, overflow} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
               busy, done, sum, c_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n, bc, both;
    logic sum_moved;
    pulse_start(8'h0F, 8'h01, 1'b0);
    n = 0; bc = 0; both = 0; sum_moved = 1'b0;
    while (!done && n < 30) begin
      if (busy) bc++;
      if (sum !== 8'h00) sum_moved = 1'b1;
      @(posedge clk); #1;
      n++;
      if (done && busy) both++;
    end
    total++;
    if (n !== 8) begin
      bad++; $display("FAIL basic_latency: done after %0d edges past start edge, want 8", n);
    end
    total++;
    if (bc !== 8) begin
      bad++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
    end
    total++;
    if (sum_moved || both != 0) begin
      bad++; $display("FAIL basic_run_ports: partial sum seen=%b done&busy count=%0d, want 0/0", sum_moved, both);
    end
    total++;
    if ({sum, c_out, overflow} !== {8'h10, 1'b0, 1'b0}) begin
      bad++; $display("FAIL basic_result: got sum=%h c_out=%b ovf=%b, want 10/0/0", sum, c_out, overflow);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h10) begin
      bad++; $display("FAIL basic_after_done: got done=%b busy=%b sum=%h, want 0/0/10", done, busy, sum);
    end
  endtask

  task automatic test_arith;
    logic [7:0] va[4] = '{8'hFF, 8'h7F, 8'h80, 8'hC3};
    logic [7:0] vb[4] = '{8'h01, 8'h01, 8'h80, 8'h3C};
    logic       vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es[4] = '{8'h00, 8'h80, 8'h00, 8'h00};
    logic       ec[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       eo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    for (int i = 0; i < 4; i++) begin
      pulse_start(va[i], vb[i], vc[i]);
      wait_done(n);
      total++;
      if (n !== 8 || {sum, c_out, overflow} !== {es[i], ec[i], eo[i]}) begin
        bad++;
        $display("FAIL arith_%0d: got edges=%0d sum=%h c_out=%b ovf=%b, want 8 %h/%b/%b",
                 i, n, sum, c_out, overflow, es[i], ec[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    pulse_start(8'h00, 8'h00, 1'b1);
    wait_done(n);
    total++;
    if (n !== 8 || {sum, c_out, overflow} !== {8'h01, 1'b0, 1'b0}) begin
      bad++; $display("FAIL b2b_first: got edges=%0d sum=%h c_out=%b ovf=%b, want 8 01/0/0", n, sum, c_out, overflow);
    end
    // Still in DONE: present the next operation with start high.
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy, done);
    end
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 9 || {sum, c_out, overflow} !== {8'hFF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL b2b_second: got edges=%0d sum=%h c_out=%b ovf=%b, want 9 FF/0/0", n, sum, c_out, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_inputs;
    int n, pulses;
    pulse_start(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'hFF - 8'(i); b = 8'hEE; c_in = 1'b1; start = (i == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(n);
    total++;
    if (n !== 5 || {sum, c_out, overflow} !== {8'h46, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ignore_result: got edges=%0d sum=%h c_out=%b ovf=%b, want 5 46/0/0", n, sum, c_out, overflow);
    end
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0 || sum !== 8'h46) begin
      bad++; $display("FAIL ignore_single_done: got extra pulses=%0d sum=%h, want 0 46", pulses, sum);
    end
  endtask

  task automatic test_reset_midrun;
    int n, pulses;
    pulse_start(8'h80, 8'h80, 1'b0);
    wait_done(n);
    total++;
    if ({sum, c_out, overflow} !== {8'h00, 1'b1, 1'b1}) begin
      bad++; $display("FAIL prereset_result: got sum=%h c_out=%b ovf=%b, want 00/1/1", sum, c_out, overflow);
    end
    pulse_start(8'h33, 8'h23, 1'b0);
    wait_done(n);
    pulse_start(8'h7E, 8'h05, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1 || sum !== 8'h56) begin
      bad++; $display("FAIL midrun_state: got busy=%b sum=%h, want 1 56", busy, sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, c_out, overflow} !== 12'h000) begin
      bad++; $display("FAIL async_reset: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
                      busy, done, sum, c_out, overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL aborted_no_done: got %0d busy/done cycles, want 0", pulses);
    end
    pulse_start(8'h7E, 8'h05, 1'b1);
    wait_done(n);
    total++;
    if (n !== 8 || {sum, c_out, overflow} !== {8'h84, 1'b0, 1'b1}) begin
      bad++; $display("FAIL post_reset_add: got edges=%0d sum=%h c_out=%b ovf=%b, want 8 84/0/1", n, sum, c_out, overflow);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
